// File: rtl/bestmatch_pkg.sv
// bestmatch_pkg: shared types and widths for the best-match selector.
//   state_e   - selector FSM states (IDLE, SCAN, DONE)
//   RES_W     - correlation score width
//   PLACE_W   - candidate place width
//   cnt_w()   - candidate counter width for a given NPLACE
//   CNT_W     - counter width for the default NPLACE of 64
package bestmatch_pkg;

    localparam int RES_W   = 18;
    localparam int PLACE_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // The counter must be able to hold NPLACE itself after the final increment.
    function automatic int cnt_w(input int nplace);
        return $clog2(nplace + 1);
    endfunction

    localparam int CNT_W = cnt_w(64);

endpackage

// File: rtl/bestmatch_select_score_compare.sv
// score_compare: combinational best / second-best update for one sample.
//   first            - this is the first sample of the scan (load unconditionally)
//   result, place    - incoming candidate
//   best_result/place- current winner
//   best_*_nxt       - winner after this sample
//   second_best(_nxt)- runner-up score, present only with CONF_CHECK_EN
// Macro: CONF_CHECK_EN adds second-best tracking.
module score_compare
    import bestmatch_pkg::*;
(
    input  logic               first,
    input  logic [RES_W-1:0]   result,
    input  logic [PLACE_W-1:0] place,
    input  logic [RES_W-1:0]   best_result,
    input  logic [PLACE_W-1:0] best_place,
`ifdef CONF_CHECK_EN
    input  logic [RES_W-1:0]   second_best,
    output logic [RES_W-1:0]   second_best_nxt,
`endif
    output logic [RES_W-1:0]   best_result_nxt,
    output logic [PLACE_W-1:0] best_place_nxt
);

    always_comb begin
        best_result_nxt = best_result;
        best_place_nxt  = best_place;
`ifdef CONF_CHECK_EN
        second_best_nxt = second_best;
`endif
        if (first) begin
            best_result_nxt = result;
            best_place_nxt  = place;
`ifdef CONF_CHECK_EN
            // Zero keeps second_best <= best, so the margin never wraps.
            second_best_nxt = '0;
`endif
        end else if (result > best_result) begin
            // Strict compare: ties keep the earlier place.
            best_result_nxt = result;
            best_place_nxt  = place;
`ifdef CONF_CHECK_EN
            second_best_nxt = best_result;
`endif
        end
`ifdef CONF_CHECK_EN
        else if (result == best_result || result > second_best) begin
            second_best_nxt = result;
        end
`endif
    end

endmodule

// File: rtl/bestmatch_select.sv
// bestmatch_select: picks the highest-scoring place out of a scan of results.
//   clk, rst       - clock, synchronous active-high reset
//   lstart         - opens (or restarts) a scan
//   res_valid, result, place, scan_end - candidate stream from the calc stage
//   best_place, best_result, out_valid, out_ready - winner with handshake
//   busy           - scan in progress or result waiting
//   overrun        - sticky: a sample arrived while a result was waiting
//   ambiguous      - best-to-second margin below AMB_THRESH (CONF_CHECK_EN only)
// Macro: CONF_CHECK_EN enables second-best tracking and the ambiguous output.
module bestmatch_select
    import bestmatch_pkg::*;
#(
    parameter int               NPLACE     = 64,
    parameter logic [RES_W-1:0] AMB_THRESH = 18'd16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lstart,
    input  logic               res_valid,
    input  logic [RES_W-1:0]   result,
    input  logic [PLACE_W-1:0] place,
    input  logic               scan_end,
    output logic [PLACE_W-1:0] best_place,
    output logic [RES_W-1:0]   best_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
`ifdef CONF_CHECK_EN
    output logic               ambiguous,
`endif
    output logic               overrun
);

    localparam int CW = cnt_w(NPLACE);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               seen_q, seen_d;
    logic [RES_W-1:0]   best_result_q, best_result_d, best_result_nxt;
    logic [PLACE_W-1:0] best_place_q, best_place_d, best_place_nxt;
    logic               overrun_q, overrun_d;
`ifdef CONF_CHECK_EN
    logic [RES_W-1:0]   second_q, second_d, second_nxt;
    logic               amb_q, amb_d;
`endif

    logic accept, last, restart, release_out;

    // A restart in the same cycle as a sample wins; the sample is dropped.
    assign accept      = (state_q == SCAN) && res_valid && !lstart;
    assign last        = scan_end || (cnt_q == CW'(NPLACE - 1));
    assign release_out = (state_q == DONE) && out_ready;
    assign restart     = lstart && ((state_q == IDLE) || (state_q == SCAN) || release_out);

    score_compare u_cmp (
        .first           (!seen_q),
        .result          (result),
        .place           (place),
        .best_result     (best_result_q),
        .best_place      (best_place_q),
`ifdef CONF_CHECK_EN
        .second_best     (second_q),
        .second_best_nxt (second_nxt),
`endif
        .best_result_nxt (best_result_nxt),
        .best_place_nxt  (best_place_nxt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (lstart) state_d = SCAN;
            SCAN: begin
                if (lstart)              state_d = SCAN;
                else if (accept && last) state_d = DONE;
            end
            DONE: begin
                if (release_out) state_d = lstart ? SCAN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // Datapath next values
    always_comb begin
        cnt_d         = cnt_q;
        seen_d        = seen_q;
        best_result_d = best_result_q;
        best_place_d  = best_place_q;
        overrun_d     = overrun_q | ((state_q == DONE) && res_valid);
`ifdef CONF_CHECK_EN
        second_d      = second_q;
        amb_d         = amb_q;
`endif
        if (restart) begin
            cnt_d  = '0;
            seen_d = 1'b0;
        end else if (accept) begin
            cnt_d         = cnt_q + 1'b1;
            seen_d        = 1'b1;
            best_result_d = best_result_nxt;
            best_place_d  = best_place_nxt;
`ifdef CONF_CHECK_EN
            second_d      = second_nxt;
`endif
        end
`ifdef CONF_CHECK_EN
        // second_nxt <= best_result_nxt always, so the margin is non-negative.
        if (accept && last)
            amb_d = seen_q && ((best_result_nxt - second_nxt) < AMB_THRESH);
        else if (release_out)
            amb_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            seen_q        <= 1'b0;
            best_result_q <= '0;
            best_place_q  <= '0;
            overrun_q     <= 1'b0;
`ifdef CONF_CHECK_EN
            second_q      <= '0;
            amb_q         <= 1'b0;
`endif
        end else begin
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            best_result_q <= best_result_d;
            best_place_q  <= best_place_d;
            overrun_q     <= overrun_d;
`ifdef CONF_CHECK_EN
            second_q      <= second_d;
            amb_q         <= amb_d;
`endif
        end
    end

    assign best_result = best_result_q;
    assign best_place  = best_place_q;
    assign overrun     = overrun_q;
`ifdef CONF_CHECK_EN
    assign ambiguous   = amb_q;
`endif

endmodule

// File: tb/tb_bestmatch_select.sv
module tb_bestmatch_select;

    logic        clk = 1'b0;
    logic        rst, lstart, res_valid, scan_end, out_ready;
    logic [17:0] result;
    logic [5:0]  place;
    logic [5:0]  best_place;
    logic [17:0] best_result;
    logic        out_valid, busy, overrun;
`ifdef CONF_CHECK_EN
    logic        ambiguous;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bestmatch_select #(.NPLACE(4), .AMB_THRESH(18'd16)) dut (
        .clk         (clk),
        .rst         (rst),
        .lstart      (lstart),
        .res_valid   (res_valid),
        .result      (result),
        .place       (place),
        .scan_end    (scan_end),
        .best_place  (best_place),
        .best_result (best_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
`ifdef CONF_CHECK_EN
        .ambiguous   (ambiguous),
`endif
        .overrun     (overrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_scan();
        lstart = 1'b1;
        step();
        lstart = 1'b0;
    endtask

    task automatic send(input logic [17:0] r, input logic [5:0] p, input logic se);
        res_valid = 1'b1; result = r; place = p; scan_end = se;
        step();
        res_valid = 1'b0; scan_end = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++; if (best_result !== 18'd0) begin errors++; $display("FAIL reset_best_result got %0d want 0", best_result); end
        checks++; if (best_place !== 6'd0) begin errors++; $display("FAIL reset_best_place got %0d want 0", best_place); end
    endtask

    task automatic test_basic();
        start_scan();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
        send(18'd5, 6'd0, 1'b0);
        send(18'd40, 6'd1, 1'b0);
        send(18'd12, 6'd2, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
        send(18'd7, 6'd3, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
        checks++; if (best_place !== 6'd1) begin errors++; $display("FAIL basic_best_place got %0d want 1", best_place); end
        checks++; if (best_result !== 18'd40) begin errors++; $display("FAIL basic_best_result got %0d want 40", best_result); end
`ifdef CONF_CHECK_EN
        checks++; if (ambiguous !== 1'b0) begin errors++; $display("FAIL basic_ambiguous got %b want 0", ambiguous); end
`endif
        handshake();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_release got valid=%b busy=%b want 0 0", out_valid, busy); end
        checks++; if (best_result !== 18'd40) begin errors++; $display("FAIL basic_retain got %0d want 40", best_result); end
        // Samples in IDLE are ignored
        send(18'd99, 6'd9, 1'b1);
        checks++; if (busy !== 1'b0 || best_result !== 18'd40) begin errors++; $display("FAIL idle_ignore got busy=%b res=%0d want 0 40", busy, best_result); end
    endtask

    task automatic test_tie();
        start_scan();
        send(18'd30, 6'd2, 1'b0);
        send(18'd30, 6'd5, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tie_out_valid got %b want 1", out_valid); end
        checks++; if (best_place !== 6'd2) begin errors++; $display("FAIL tie_best_place got %0d want 2", best_place); end
        checks++; if (best_result !== 18'd30) begin errors++; $display("FAIL tie_best_result got %0d want 30", best_result); end
`ifdef CONF_CHECK_EN
        checks++; if (ambiguous !== 1'b1) begin errors++; $display("FAIL tie_ambiguous got %b want 1", ambiguous); end
`endif
        handshake();
    endtask

    task automatic test_count_end();
        start_scan();
        send(18'd1, 6'd0, 1'b0);
        send(18'd2, 6'd1, 1'b0);
        send(18'd3, 6'd2, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cnt_early_valid got %b want 0", out_valid); end
        send(18'd9, 6'd3, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cnt_out_valid got %b want 1", out_valid); end
        checks++; if (best_place !== 6'd3 || best_result !== 18'd9) begin errors++; $display("FAIL cnt_best got place=%0d res=%0d want 3 9", best_place, best_result); end
`ifdef CONF_CHECK_EN
        checks++; if (ambiguous !== 1'b1) begin errors++; $display("FAIL cnt_ambiguous got %b want 1", ambiguous); end
`endif
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL cnt_no_overrun got %b want 0", overrun); end
        send(18'd50, 6'd0, 1'b0);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", overrun); end
        checks++; if (best_result !== 18'd9 || out_valid !== 1'b1) begin errors++; $display("FAIL overrun_discard got res=%0d valid=%b want 9 1", best_result, out_valid); end
        handshake();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b want 1", overrun); end
    endtask

    task automatic test_restart();
        start_scan();
        send(18'd100, 6'd0, 1'b0);
        send(18'd50, 6'd1, 1'b0);
        // Restart collides with a sample: the sample must be dropped
        lstart = 1'b1; res_valid = 1'b1; result = 18'd200; place = 6'd7;
        step();
        lstart = 1'b0; res_valid = 1'b0;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL restart_state got busy=%b valid=%b want 1 0", busy, out_valid); end
        send(18'd8, 6'd6, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL restart_out_valid got %b want 1", out_valid); end
        checks++; if (best_place !== 6'd6 || best_result !== 18'd8) begin errors++; $display("FAIL restart_best got place=%0d res=%0d want 6 8", best_place, best_result); end
`ifdef CONF_CHECK_EN
        checks++; if (ambiguous !== 1'b0) begin errors++; $display("FAIL single_ambiguous got %b want 0", ambiguous); end
`endif
    endtask

    task automatic test_hold();
        int bad = 0;
        lstart = 1'b1;
        step();
        lstart = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || busy !== 1'b1 || best_place !== 6'd6 || best_result !== 18'd8) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
        out_ready = 1'b1; lstart = 1'b1;
        step();
        out_ready = 1'b0; lstart = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL back_to_back got valid=%b busy=%b want 0 1", out_valid, busy); end
    endtask

    task automatic test_rst_mid();
        send(18'd10, 6'd0, 1'b0);
        send(18'd20, 6'd1, 1'b0);
        send(18'd15, 6'd2, 1'b0);
        rst = 1'b1; res_valid = 1'b1; result = 18'd77; place = 6'd3; scan_end = 1'b1;
        step();
        rst = 1'b0; res_valid = 1'b0; scan_end = 1'b0;
        checks++; if (best_place !== 6'd0 || best_result !== 18'd0) begin errors++; $display("FAIL rst_mid_best got place=%0d res=%0d want 0 0", best_place, best_result); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got valid=%b busy=%b ovr=%b want 0 0 0", out_valid, busy, overrun); end
`ifdef CONF_CHECK_EN
        checks++; if (ambiguous !== 1'b0) begin errors++; $display("FAIL rst_mid_ambiguous got %b want 0", ambiguous); end
`endif
        send(18'd99, 6'd1, 1'b1);
        step();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || best_result !== 18'd0) begin errors++; $display("FAIL rst_idle_ignore got busy=%b valid=%b res=%0d want 0 0 0", busy, out_valid, best_result); end
    endtask

    initial begin
        rst = 1'b1; lstart = 1'b0; res_valid = 1'b0; scan_end = 1'b0;
        out_ready = 1'b0; result = '0; place = '0;
        test_reset();
        test_basic();
        test_tie();
        test_count_end();
        test_restart();
        test_hold();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bestmatch_select.md
BESTMATCH_SELECT -- requirements
Module: bestmatch_select

Interface
REQ-001 Parameter NPLACE, default 64; number of candidate places per scan, range 2..64.
REQ-002 Parameter AMB_THRESH, default 18'd16; minimum best-to-second margin for an unambiguous match.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 lstart  input  1  one-cycle pulse that opens a new scan.
REQ-006 res_valid  input  1  result/place pair from the upstream calc stage is valid this cycle.
REQ-007 result  input  18  correlation score; unsigned; larger is better.
REQ-008 place  input  6  candidate place of this result.
REQ-009 scan_end  input  1  qualifies res_valid; marks the last candidate of the scan.
REQ-010 best_place  output  6  place of the winning candidate.
REQ-011 best_result  output  18  score of the winning candidate.
REQ-012 out_valid  output  1  best_place/best_result are valid.
REQ-013 out_ready  input  1  downstream accepts the output.
REQ-014 busy  output  1  high in SCAN and DONE.
REQ-015 overrun  output  1  sticky error flag.
REQ-016 ambiguous  output  1  low-confidence match; present only with CONF_CHECK_EN.

Function
REQ-017 FSM states: IDLE, SCAN, DONE.
REQ-018 IDLE -> SCAN on lstart.
- Clears the candidate counter and the first-sample flag.
- res_valid in IDLE is ignored.
REQ-019 Best-score load/update in SCAN:
- First res_valid loads best_result/best_place unconditionally.
- Each later res_valid replaces them only if result > best_result (strict compare).
- Ties keep the earlier-arriving place.
REQ-020 The candidate counter increments on each res_valid in SCAN.
REQ-021 SCAN -> DONE on the accepting cycle of either:
- res_valid with scan_end; or
- the NPLACE-th res_valid, even without scan_end.
REQ-022 Output latency: out_valid rises the cycle after the final accepted res_valid; best_* are already updated in that cycle.
REQ-023 lstart during SCAN aborts the scan and restarts it: counter and first-sample flag cleared, no output produced.
REQ-024 lstart in the same cycle as a res_valid in SCAN: the restart wins and that sample is discarded.
REQ-025 DONE holds out_valid and stable best_* until out_ready.
- out_ready alone -> IDLE.
- out_ready and lstart in the same cycle -> SCAN directly; the handshake completes.
- lstart without out_ready in DONE is ignored.
REQ-026 res_valid in DONE sets overrun; that sample is discarded.
REQ-027 overrun clears only on rst.
REQ-028 best_* are not cleared on entering IDLE; they retain the last result.
REQ-029 All comparisons are 18-bit unsigned.
- No score arithmetic beyond the CONF_CHECK_EN margin in REQ-035.
- Any subtraction is 18-bit with no wrap; its result is non-negative by construction.

Reset
REQ-030 rst forces IDLE from any state, including mid-scan, and discards any partial scan.
REQ-031 rst clears: best_place=0, best_result=0, out_valid=0, busy=0, overrun=0, ambiguous=0, counter=0, second-best=0.
REQ-032 In-flight inputs in the cycle rst is asserted are ignored.

Configuration
REQ-033 The macro CONF_CHECK_EN compiles in second-best tracking and the ambiguous port.
REQ-034 With CONF_CHECK_EN, second-best tracking works as follows:
- When a new best arrives, the old best score moves to second-best.
- A non-winning result greater than second-best replaces second-best.
- A result equal to best also updates second-best.
REQ-035 With CONF_CHECK_EN, ambiguous is registered with out_valid.
- ambiguous = 1 when (best_result - second_best) < AMB_THRESH.
- A single-sample scan sets ambiguous = 0.
REQ-036 Without CONF_CHECK_EN, the ambiguous port, second-best register and margin logic are absent; all other behaviour is identical.

Structure
REQ-037 Shared package bestmatch_pkg holds:
- FSM state enum;
- width constants RES_W=18, PLACE_W=6;
- CNT_W derived from NPLACE.
REQ-038 One sub-module, score_compare, does the best/second-best compare and update; the FSM and counter stay in bestmatch_select.

Verification
REQ-039 Scan places 0..3, results 5,40,12,7, scan_end on place 3 -> next cycle out_valid=1, best_place=1, best_result=40.
REQ-040 Tie: results 30,30 at places 2,5 -> best_place=2; with CONF_CHECK_EN, ambiguous=1 (margin 0 < 16).
REQ-041 No scan_end; NPLACE=4; results 1,2,3,9 -> DONE after the 4th sample, best_place=3; a 5th res_valid sets overrun=1.
REQ-042 lstart after 2 samples (result 100 at place 0), then a new scan with 8 at place 6 carrying scan_end -> best_place=6, best_result=8.
REQ-043 out_ready held low 10 cycles in DONE -> outputs stable, busy=1; out_ready and lstart together -> next cycle state SCAN, out_valid=0.
REQ-044 rst mid-scan after 3 samples -> next cycle all outputs 0, state IDLE; res_valid without lstart is ignored.
